irq_class_sched: RTL and testbench
==================================

# irq_class_sched

Sequential scheduler for the 9-channel, three-class interrupt datapath. Each channel raises requests in classes A, B and C, and a per-channel enable mask gates them. The block chooses one channel at a time: strict priority between classes, round-robin within a class. It offers the channel to the service engine over a valid/ready handshake and supervises the service with a timeout. It sits between the raw channel request lines and the shared service engine, replacing the combinational priority decode as the single source of "who is served next".

## Interface
Parameters:
- N_CH, 9, number of channels (2..16); channel index width is fixed at 4 bits.
- TIMEOUT, 16, cycles allowed in SERVICE before abort (>= 2).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_a  in  N_CH  class A requests, level-sensitive, highest class
- req_b  in  N_CH  class B requests
- req_c  in  N_CH  class C requests, lowest class
- en_wr  in  1  write strobe for enable mask
- en_data  in  N_CH  new enable mask
- en_mask  out  N_CH  current enable mask
- pend  out  3  registered per-class pending flags {C,B,A}
- grant_valid  out  1  offer valid
- grant_ready  in  1  service engine accepts offer
- grant_class  out  2  0=A, 1=B, 2=C; 3 never driven
- grant_chan  out  4  offered channel index
- busy  out  1  high while in SERVICE
- svc_done  in  1  single-cycle completion pulse from service engine
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

## Operation
- Effective request for class k is req_k & en_mask.
- pend[k] is high when any bit of class k's effective request is set, registered each cycle in every state.
- en_mask:
  - loads en_data on en_wr; reset value all ones;
  - a write never cancels an in-flight offer or service.
- Round-robin pointers ptr_a, ptr_b and ptr_c (4 bits each) reset to 0.
- Arbitration:
  - pick the highest class with any effective request;
  - within that class, pick the first set bit scanning upward from ptr_k, wrapping from N_CH-1 to 0.
- FSM states: IDLE, OFFER, SERVICE. Reset state is IDLE.
- IDLE:
  - if any effective request exists, register the class and channel, then go to OFFER;
  - otherwise stay in IDLE.
- OFFER:
  - grant_valid=1; grant_class and grant_chan are held stable;
  - no re-arbitration, even if the request drops or its enable is cleared;
  - when grant_ready=1: set ptr_k for the granted class to (chan+1) mod N_CH, clear the counter, go to SERVICE.
- SERVICE:
  - busy=1, and the counter increments each cycle;
  - svc_done=1 -> go to IDLE;
  - counter reaches TIMEOUT-1 with svc_done=0 -> set timeout_err and go to IDLE;
  - svc_done on the terminal count cycle wins: no error is flagged.
- svc_done outside SERVICE is ignored.
- timeout_err:
  - err_clr clears it;
  - if the set and clear conditions occur in the same cycle, set wins.
- Outputs in IDLE and SERVICE: grant_valid=0; grant_class and grant_chan keep their last values.

## Timing
- Reset values:
  - grant_valid=0, grant_class=0, grant_chan=0;
  - busy=0, timeout_err=0, pend=0;
  - en_mask all ones; all ptrs 0.
- Reset asserted mid-offer or mid-service returns every register to its reset value on that edge. No done or error is generated.
- Request-to-offer latency: a request sampled in IDLE at edge t gives grant_valid=1 after edge t+1.
- Handshake transfer occurs at the edge where grant_valid & grant_ready; busy=1 from the next cycle.
- Done-to-next-offer: svc_done at edge t puts the FSM in IDLE after t. The earliest next grant_valid is after edge t+1, a 2-cycle gap.
- Timeout is abort at the end of the TIMEOUT-th SERVICE cycle; timeout_err is visible the next cycle.
- pend lags the request inputs by exactly one cycle.
- en_wr at edge t affects the arbitration decision taken at edge t+1.

## Test plan
- Single request: req_c=9'h010, others 0. Expect grant_valid after 2 edges with class=2, chan=4. Assert ready, then svc_done 3 cycles later; busy high for 3 cycles, then IDLE with grant_valid=0.
- Class priority: req_a=9'h100, req_b=9'h001 and req_c=9'h001 together. Expect grants A/8 first, then B/0, then C/0, each after svc_done. pend goes 3'b111 -> 3'b110 -> 3'b100 -> 0 as the requests drop.
- Round-robin wrap: req_b=9'h1FF held with immediate ready and done. Expect the channel sequence 0,1,…,8,0, with ptr_b wrapping 8 -> 0.
- Enable mask: en_wr with en_data=9'h1FE while req_a=9'h001 and req_b=9'h002. Expect B/1 to be granted, and class A never to be offered.
- Timeout with TIMEOUT=16: grant, then no svc_done. Expect busy=1 for 16 cycles, then IDLE with timeout_err=1. err_clr and a new timeout in the same cycle leave it at 1. svc_done exactly on cycle 16 gives no error.
- Offer stability: hold grant_ready=0 for 5 cycles while the request drops and req_a rises. Expect grant_class and grant_chan unchanged. Reset asserted in OFFER clears grant_valid and en_mask=all ones on the next edge.

Source files
------------

// File: rtl/irq_class_sched.sv
// Three-class interrupt scheduler: strict priority across classes A>B>C,
// round-robin within a class, valid/ready offer and timeout-supervised service.
module irq_class_sched #(
  parameter int unsigned N_CH    = 9,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] req_a,
  input  logic [N_CH-1:0] req_b,
  input  logic [N_CH-1:0] req_c,
  input  logic            en_wr,
  input  logic [N_CH-1:0] en_data,
  output logic [N_CH-1:0] en_mask,
  output logic [2:0]      pend,
  output logic            grant_valid,
  input  logic            grant_ready,
  output logic [1:0]      grant_class,
  output logic [3:0]      grant_chan,
  output logic            busy,
  input  logic            svc_done,
  output logic            timeout_err,
  input  logic            err_clr
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_OFFER, S_SERVICE} state_t;

  state_t          state_q, state_d;
  logic [N_CH-1:0] req_a_q, req_b_q, req_c_q;
  logic [N_CH-1:0] en_mask_q, en_mask_d;
  logic [2:0]      pend_q, pend_d;
  logic [3:0]      ptr_a_q, ptr_a_d, ptr_b_q, ptr_b_d, ptr_c_q, ptr_c_d;
  logic [1:0]      grant_class_q, grant_class_d;
  logic [3:0]      grant_chan_q, grant_chan_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_err_q, timeout_err_d;

  logic [N_CH-1:0] eff_a, eff_b, eff_c;
  logic [4:0]      pick_a, pick_b, pick_c;
  logic [3:0]      ptr_next;
  logic            err_set;

  // Returns {found, index}: first set bit at or above ptr, wrapping at N_CH-1.
  function automatic logic [4:0] rr_pick(input logic [N_CH-1:0] r, input logic [3:0] ptr);
    logic        found;
    logic [3:0]  idx;
    int unsigned j;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      j = 32'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (!found && r[j[3:0]]) begin
        found = 1'b1;
        idx   = j[3:0];
      end
    end
    return {found, idx};
  endfunction

  // Arbitration runs on the registered request lines, so a request sampled
  // at one edge is decided at the next.
  always_comb begin
    eff_a  = req_a_q & en_mask_q;
    eff_b  = req_b_q & en_mask_q;
    eff_c  = req_c_q & en_mask_q;
    pick_a = rr_pick(eff_a, ptr_a_q);
    pick_b = rr_pick(eff_b, ptr_b_q);
    pick_c = rr_pick(eff_c, ptr_c_q);
    ptr_next = (grant_chan_q == 4'(N_CH - 1)) ? '0 : grant_chan_q + 4'd1;
  end

  always_comb begin
    state_d       = state_q;
    grant_class_d = grant_class_q;
    grant_chan_d  = grant_chan_q;
    ptr_a_d       = ptr_a_q;
    ptr_b_d       = ptr_b_q;
    ptr_c_d       = ptr_c_q;
    cnt_d         = cnt_q;
    err_set       = 1'b0;
    en_mask_d     = en_wr ? en_data : en_mask_q;
    pend_d        = {|(req_c & en_mask_q), |(req_b & en_mask_q), |(req_a & en_mask_q)};

    unique case (state_q)
      S_IDLE: begin
        if (pick_a[4]) begin
          grant_class_d = 2'd0;
          grant_chan_d  = pick_a[3:0];
          state_d       = S_OFFER;
        end else if (pick_b[4]) begin
          grant_class_d = 2'd1;
          grant_chan_d  = pick_b[3:0];
          state_d       = S_OFFER;
        end else if (pick_c[4]) begin
          grant_class_d = 2'd2;
          grant_chan_d  = pick_c[3:0];
          state_d       = S_OFFER;
        end
      end
      S_OFFER: begin
        if (grant_ready) begin
          case (grant_class_q)
            2'd0:    ptr_a_d = ptr_next;
            2'd1:    ptr_b_d = ptr_next;
            default: ptr_c_d = ptr_next;
          endcase
          cnt_d   = '0;
          state_d = S_SERVICE;
        end
      end
      S_SERVICE: begin
        cnt_d = cnt_q + CW'(1);
        if (svc_done) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    timeout_err_d = err_set | (timeout_err_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      req_a_q       <= '0;
      req_b_q       <= '0;
      req_c_q       <= '0;
      en_mask_q     <= '1;
      pend_q        <= '0;
      ptr_a_q       <= '0;
      ptr_b_q       <= '0;
      ptr_c_q       <= '0;
      grant_class_q <= '0;
      grant_chan_q  <= '0;
      cnt_q         <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_a_q       <= req_a;
      req_b_q       <= req_b;
      req_c_q       <= req_c;
      en_mask_q     <= en_mask_d;
      pend_q        <= pend_d;
      ptr_a_q       <= ptr_a_d;
      ptr_b_q       <= ptr_b_d;
      ptr_c_q       <= ptr_c_d;
      grant_class_q <= grant_class_d;
      grant_chan_q  <= grant_chan_d;
      cnt_q         <= cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign en_mask     = en_mask_q;
  assign pend        = pend_q;
  assign grant_valid = (state_q == S_OFFER);
  assign busy        = (state_q == S_SERVICE);
  assign grant_class = grant_class_q;
  assign grant_chan  = grant_chan_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_irq_class_sched.sv
// Directed bench for irq_class_sched: table of single-grant transactions plus
// hand-written priority, round-robin wrap, timeout and offer-stability sequences.
module tb_irq_class_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] req_a, req_b, req_c;
  logic       en_wr;
  logic [8:0] en_data;
  logic [8:0] en_mask;
  logic [2:0] pend;
  logic       grant_valid, grant_ready;
  logic [1:0] grant_class;
  logic [3:0] grant_chan;
  logic       busy, svc_done, timeout_err, err_clr;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  irq_class_sched #(.N_CH(9), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .req_b(req_b), .req_c(req_c),
    .en_wr(en_wr), .en_data(en_data), .en_mask(en_mask),
    .pend(pend),
    .grant_valid(grant_valid), .grant_ready(grant_ready),
    .grant_class(grant_class), .grant_chan(grant_chan),
    .busy(busy), .svc_done(svc_done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a, b, c;
    logic       wr;
    logic [8:0] en;
    logic [1:0] cls;
    logic [3:0] chan;
    logic [2:0] pnd;
  } vec_t;

  vec_t tbl[11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Accept the pending offer, load new request levels, serve ncyc cycles
  // with svc_done on the last one.
  task automatic accept_and_serve(input int unsigned ncyc,
                                  input logic [8:0] na, input logic [8:0] nb,
                                  input logic [8:0] nc);
    grant_ready = 1'b1;
    tick();
    grant_ready = 1'b0;
    req_a = na; req_b = nb; req_c = nc;
    for (int unsigned i = 0; i < ncyc; i++) begin
      chk("busy_in_service", 32'(busy), 1);
      if (i == ncyc - 1) svc_done = 1'b1;
      tick();
    end
    svc_done = 1'b0;
    chk("busy_after_done", 32'(busy), 0);
    chk("valid_after_done", 32'(grant_valid), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [8:0] exp_mask;
    rst = 1'b0; req_a = '0; req_b = '0; req_c = '0;
    en_wr = 1'b0; en_data = '0; grant_ready = 1'b0; svc_done = 1'b0; err_clr = 1'b0;
    exp_mask = 9'h1FF;

    tbl[0]  = '{a:9'h000, b:9'h000, c:9'h010, wr:1'b0, en:9'h000, cls:2'd2, chan:4'd4, pnd:3'b100};
    tbl[1]  = '{a:9'h000, b:9'h003, c:9'h000, wr:1'b0, en:9'h000, cls:2'd1, chan:4'd0, pnd:3'b010};
    tbl[2]  = '{a:9'h000, b:9'h003, c:9'h000, wr:1'b0, en:9'h000, cls:2'd1, chan:4'd1, pnd:3'b010};
    tbl[3]  = '{a:9'h000, b:9'h003, c:9'h000, wr:1'b0, en:9'h000, cls:2'd1, chan:4'd0, pnd:3'b010};
    tbl[4]  = '{a:9'h180, b:9'h000, c:9'h1FF, wr:1'b0, en:9'h000, cls:2'd0, chan:4'd7, pnd:3'b101};
    tbl[5]  = '{a:9'h181, b:9'h000, c:9'h000, wr:1'b0, en:9'h000, cls:2'd0, chan:4'd8, pnd:3'b001};
    tbl[6]  = '{a:9'h000, b:9'h000, c:9'h018, wr:1'b0, en:9'h000, cls:2'd2, chan:4'd3, pnd:3'b100};
    tbl[7]  = '{a:9'h000, b:9'h100, c:9'h010, wr:1'b0, en:9'h000, cls:2'd1, chan:4'd8, pnd:3'b110};
    tbl[8]  = '{a:9'h000, b:9'h000, c:9'h010, wr:1'b0, en:9'h000, cls:2'd2, chan:4'd4, pnd:3'b100};
    tbl[9]  = '{a:9'h001, b:9'h002, c:9'h000, wr:1'b1, en:9'h1FE, cls:2'd1, chan:4'd1, pnd:3'b010};
    tbl[10] = '{a:9'h001, b:9'h000, c:9'h000, wr:1'b1, en:9'h1FF, cls:2'd0, chan:4'd0, pnd:3'b001};

    do_reset();
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_class", 32'(grant_class), 0);
    chk("rst_chan", 32'(grant_chan), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_pend", 32'(pend), 0);
    chk("rst_mask", 32'(en_mask), 32'h1FF);

    // Single-grant transactions, 3-cycle service each
    for (int i = 0; i < 11; i++) begin
      req_a = tbl[i].a; req_b = tbl[i].b; req_c = tbl[i].c;
      en_wr = tbl[i].wr; en_data = tbl[i].en;
      if (tbl[i].wr) exp_mask = tbl[i].en;
      tick();
      en_wr = 1'b0;
      chk("tbl_latency", 32'(grant_valid), 0);
      tick();
      chk("tbl_valid", 32'(grant_valid), 1);
      chk("tbl_class", 32'(grant_class), 32'(tbl[i].cls));
      chk("tbl_chan", 32'(grant_chan), 32'(tbl[i].chan));
      chk("tbl_pend", 32'(pend), 32'(tbl[i].pnd));
      chk("tbl_mask", 32'(en_mask), 32'(exp_mask));
      accept_and_serve(3, '0, '0, '0);
    end

    // Class priority with requests held until served
    req_a = 9'h100; req_b = 9'h001; req_c = 9'h001;
    tick(); tick();
    chk("prio_pend0", 32'(pend), 7);
    chk("prio_valid_a", 32'(grant_valid), 1);
    chk("prio_class_a", 32'(grant_class), 0);
    chk("prio_chan_a", 32'(grant_chan), 8);
    accept_and_serve(3, 9'h000, 9'h001, 9'h001);
    chk("prio_pend1", 32'(pend), 6);
    tick();
    chk("prio_valid_b", 32'(grant_valid), 1);
    chk("prio_class_b", 32'(grant_class), 1);
    chk("prio_chan_b", 32'(grant_chan), 0);
    accept_and_serve(3, 9'h000, 9'h000, 9'h001);
    chk("prio_pend2", 32'(pend), 4);
    tick();
    chk("prio_valid_c", 32'(grant_valid), 1);
    chk("prio_class_c", 32'(grant_class), 2);
    chk("prio_chan_c", 32'(grant_chan), 0);
    accept_and_serve(3, '0, '0, '0);
    chk("prio_pend3", 32'(pend), 0);
    tick();
    chk("prio_idle", 32'(grant_valid), 0);

    // Round-robin wrap in class B from a fresh pointer
    do_reset();
    req_b = 9'h1FF;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("rr_valid", 32'(grant_valid), 1);
      chk("rr_class", 32'(grant_class), 1);
      chk("rr_chan", 32'(grant_chan), 32'(i % 9));
      accept_and_serve(1, '0, (i == 9) ? 9'h000 : 9'h1FF, '0);
      if (i < 9) tick();
    end
    tick();
    chk("rr_idle", 32'(grant_valid), 0);

    // Timeout: no done for 16 service cycles
    req_a = 9'h001;
    tick(); tick();
    chk("to_class", 32'(grant_class), 0);
    chk("to_chan", 32'(grant_chan), 0);
    grant_ready = 1'b1; tick(); grant_ready = 1'b0; req_a = '0;
    for (int i = 0; i < 16; i++) begin
      chk("to_busy", 32'(busy), 1);
      chk("to_err_early", 32'(timeout_err), 0);
      tick();
    end
    chk("to_busy_end", 32'(busy), 0);
    chk("to_err_set", 32'(timeout_err), 1);
    tick();
    chk("to_err_sticky", 32'(timeout_err), 1);

    // Second timeout with err_clr on the abort edge: set wins
    req_a = 9'h001;
    tick(); tick();
    chk("to2_valid", 32'(grant_valid), 1);
    grant_ready = 1'b1; tick(); grant_ready = 1'b0; req_a = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) err_clr = 1'b1;
      tick();
    end
    err_clr = 1'b0;
    chk("to2_set_wins", 32'(timeout_err), 1);
    chk("to2_idle", 32'(busy), 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_clr", 32'(timeout_err), 0);

    // Done exactly on the terminal-count cycle
    req_a = 9'h001;
    tick(); tick();
    chk("to3_valid", 32'(grant_valid), 1);
    accept_and_serve(16, '0, '0, '0);
    chk("to3_no_err", 32'(timeout_err), 0);

    // Offer held stable while requests and mask change; reset inside offer
    req_b = 9'h004;
    tick(); tick();
    chk("stab_valid0", 32'(grant_valid), 1);
    chk("stab_chan0", 32'(grant_chan), 2);
    req_b = '0; req_a = 9'h1FF; en_wr = 1'b1; en_data = 9'h000;
    for (int i = 0; i < 5; i++) begin
      tick();
      en_wr = 1'b0;
      chk("stab_valid", 32'(grant_valid), 1);
      chk("stab_class", 32'(grant_class), 1);
      chk("stab_chan", 32'(grant_chan), 2);
    end
    chk("stab_mask", 32'(en_mask), 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; req_a = '0;
    chk("ofr_rst_valid", 32'(grant_valid), 0);
    chk("ofr_rst_mask", 32'(en_mask), 32'h1FF);
    chk("ofr_rst_class", 32'(grant_class), 0);
    chk("ofr_rst_chan", 32'(grant_chan), 0);
    chk("ofr_rst_pend", 32'(pend), 0);
    tick(); tick();
    chk("ofr_rst_idle", 32'(grant_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
